// File: rtl/music_pkg.sv
// Shared definitions for the music voice arbiter: state encoding, note codes, jingle tables.
package music_pkg;

  localparam int unsigned NOTE_W = 7;

  typedef enum logic [2:0] {
    ST_SONG   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_JINGLE = 3'd2,
    ST_REST   = 3'd3,
    ST_PAUSE  = 3'd4
  } state_e;

  localparam logic [NOTE_W-1:0] REST_CODE     = 7'h2D;
  localparam logic [2:0]        JINGLE_OCTAVE = 3'd2;
  localparam logic [2:0]        JINGLE_LAST   = 3'd5;

  // Jingle note numbers, entry [0] plays first.
  localparam logic [5:0][3:0] JINGLE_V1_NOTES = {4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  localparam logic [5:0][3:0] JINGLE_V2_NOTES = {4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  // Note code = {octave, note}.
  function automatic logic [NOTE_W-1:0] note_code(input logic [2:0] octave,
                                                  input logic [3:0] note);
    return {octave, note};
  endfunction

endpackage

// File: rtl/jingle_rom.sv
// Game-over jingle lookup: note index -> voice-1/voice-2 note codes.
//   idx  in  3  jingle note index (0..5 valid, others return the rest code)
//   v1   out 7  voice-1 note code
//   v2   out 7  voice-2 note code
module jingle_rom
  import music_pkg::*;
(
  input  logic [2:0]        idx,
  output logic [NOTE_W-1:0] v1,
  output logic [NOTE_W-1:0] v2
);

  always_comb begin
    v1 = REST_CODE;
    v2 = REST_CODE;
    if (idx <= JINGLE_LAST) begin
      v1 = note_code(JINGLE_OCTAVE, JINGLE_V1_NOTES[idx]);
      v2 = note_code(JINGLE_OCTAVE, JINGLE_V2_NOTES[idx]);
    end
  end

endmodule

// File: rtl/music_voice_arbiter.sv
// Scheduler for the two tone voices: background song, line-clear sweep,
// game-over jingle, or rest/pause silence. All outputs are registered and
// follow the next-state decode so they change on the edge that loads the state.
//   clk, rst_n              clock, async active-low reset
//   song_freq1/2            song reader note codes
//   full_row                rising edge requests the line-clear sweep
//   game_over               jingle request (then rest until released)
//   pause                   pause request
//   voice1_freq/voice2_freq note codes to freq_gen
//   song_hold               stall song readers (any state but SONG)
//   sfx_busy                sweep or jingle active
//   state_dbg               {1'b0, state} for LEDs
module music_voice_arbiter
  import music_pkg::*;
#(
  parameter int unsigned SWEEP_LOG2  = 23,
  parameter int unsigned JINGLE_LOG2 = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] song_freq1,
  input  logic [NOTE_W-1:0] song_freq2,
  input  logic              full_row,
  input  logic              game_over,
  input  logic              pause,
  output logic [NOTE_W-1:0] voice1_freq,
  output logic [NOTE_W-1:0] voice2_freq,
  output logic              song_hold,
  output logic              sfx_busy,
  output logic [3:0]        state_dbg
);

  state_e                  state_q, state_d;
  logic [SWEEP_LOG2-1:0]   scnt_q, scnt_d;
  logic [JINGLE_LOG2-1:0]  jcnt_q, jcnt_d;
  logic [2:0]              jidx_q, jidx_d;
  logic                    fr_q;
  logic                    fr_rise_c;
  logic                    sweep_hold_c;
  logic [NOTE_W-1:0]       rom_v1_c, rom_v2_c;
  logic [NOTE_W-1:0]       v1_d, v2_d;

  assign fr_rise_c = full_row & ~fr_q;

  // ROM is addressed with the next index so the registered voice lines up with the new note.
  jingle_rom u_jingle_rom (
    .idx (jidx_d),
    .v1  (rom_v1_c),
    .v2  (rom_v2_c)
  );

  // Next-state and counter decode; priority game_over > fr_rise > pause.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    jcnt_d       = jcnt_q;
    jidx_d       = jidx_q;
    sweep_hold_c = 1'b0;
    case (state_q)
      ST_SONG, ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_JINGLE;
          jidx_d  = 3'd0;
          jcnt_d  = '0;
        end else if (fr_rise_c) begin
          state_d = ST_SWEEP;
          scnt_d  = '0;
        end else if (state_q == ST_SONG && pause) begin
          state_d = ST_PAUSE;
        end else if (state_q == ST_PAUSE && !pause) begin
          state_d = ST_SONG;
        end
      end
      ST_SWEEP: begin
        if (game_over) begin
          state_d = ST_JINGLE;
          jidx_d  = 3'd0;
          jcnt_d  = '0;
        end else if (fr_rise_c) begin
          scnt_d = '0;
        end else if (pause) begin
          sweep_hold_c = 1'b1;
        end else if (&scnt_q) begin
          state_d = ST_SONG;
        end else begin
          scnt_d = scnt_q + SWEEP_LOG2'(1);
        end
      end
      ST_JINGLE: begin
        if (&jcnt_q) begin
          jcnt_d = '0;
          if (jidx_q == JINGLE_LAST) begin
            state_d = ST_REST;
          end else begin
            jidx_d = jidx_q + 3'd1;
          end
        end else begin
          jcnt_d = jcnt_q + JINGLE_LOG2'(1);
        end
      end
      ST_REST: begin
        if (!game_over) begin
          state_d = ST_SONG;
        end
      end
      default: state_d = ST_SONG;
    endcase
  end

  // Output mux driven by the next state.
  always_comb begin
    v1_d = REST_CODE;
    v2_d = REST_CODE;
    case (state_d)
      ST_SONG: begin
        v1_d = song_freq1;
        v2_d = song_freq2;
      end
      ST_SWEEP: begin
        if (sweep_hold_c) begin
          v1_d = voice1_freq;
          v2_d = voice2_freq;
        end else begin
          v1_d = {1'b0, scnt_d[SWEEP_LOG2-1 -: 5], 1'b0};
          v2_d = song_freq2;
        end
      end
      ST_JINGLE: begin
        v1_d = rom_v1_c;
        v2_d = rom_v2_c;
      end
      default: begin
        v1_d = REST_CODE;
        v2_d = REST_CODE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SONG;
      scnt_q      <= '0;
      jcnt_q      <= '0;
      jidx_q      <= 3'd0;
      fr_q        <= 1'b0;
      voice1_freq <= REST_CODE;
      voice2_freq <= REST_CODE;
      song_hold   <= 1'b0;
      sfx_busy    <= 1'b0;
      state_dbg   <= 4'd0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      jcnt_q      <= jcnt_d;
      jidx_q      <= jidx_d;
      fr_q        <= full_row;
      voice1_freq <= v1_d;
      voice2_freq <= v2_d;
      song_hold   <= (state_d != ST_SONG);
      sfx_busy    <= (state_d == ST_SWEEP) || (state_d == ST_JINGLE);
      state_dbg   <= {1'b0, state_d};
    end
  end

endmodule

// File: tb/tb_music_voice_arbiter.sv
// Self-checking bench for music_voice_arbiter with short sweep/jingle lengths.
module tb_music_voice_arbiter;

  localparam int SW_L      = 6;
  localparam int JG_L      = 3;
  localparam int SWEEP_LEN = 1 << SW_L;
  localparam int NOTE_LEN  = 1 << JG_L;
  localparam int M_SONG = 0, M_SWEEP = 1, M_JINGLE = 2, M_REST = 3, M_PAUSE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] song1, song2;
  logic       full_row, game_over, pause;
  logic [6:0] voice1_freq, voice2_freq;
  logic       song_hold, sfx_busy;
  logic [3:0] state_dbg;

  music_voice_arbiter #(.SWEEP_LOG2(SW_L), .JINGLE_LOG2(JG_L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .song_freq1 (song1),
    .song_freq2 (song2),
    .full_row   (full_row),
    .game_over  (game_over),
    .pause      (pause),
    .voice1_freq(voice1_freq),
    .voice2_freq(voice2_freq),
    .song_hold  (song_hold),
    .sfx_busy   (sfx_busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  wire [19:0] dut_obs = {voice1_freq, voice2_freq, song_hold, sfx_busy, state_dbg};

  // Reference model: mode plus elapsed-time integers.
  logic [6:0] JV1 [6] = '{7'h2A, 7'h29, 7'h28, 7'h27, 7'h26, 7'h26};
  logic [6:0] JV2 [6] = '{7'h28, 7'h27, 7'h26, 7'h25, 7'h24, 7'h24};
  int         m_mode, m_pos, m_el;
  bit         m_prev_fr;
  logic [6:0] e_v1, e_v2;
  logic [19:0] m_exp;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [19:0] pack_exp();
    return {e_v1, e_v2, 1'(m_mode != M_SONG), 1'(m_mode == M_SWEEP || m_mode == M_JINGLE),
            4'(m_mode)};
  endfunction

  task automatic model_reset();
    m_mode = M_SONG; m_pos = 0; m_el = 0; m_prev_fr = 0;
    e_v1 = 7'h2D; e_v2 = 7'h2D;
    m_exp = pack_exp();
  endtask

  task automatic model_step();
    bit rise, frozen;
    rise = full_row && !m_prev_fr;
    m_prev_fr = full_row;
    frozen = 0;
    case (m_mode)
      M_SONG, M_PAUSE: begin
        if (game_over) begin m_mode = M_JINGLE; m_el = 0; end
        else if (rise) begin m_mode = M_SWEEP; m_pos = 0; end
        else if (m_mode == M_SONG && pause) m_mode = M_PAUSE;
        else if (m_mode == M_PAUSE && !pause) m_mode = M_SONG;
      end
      M_SWEEP: begin
        if (game_over) begin m_mode = M_JINGLE; m_el = 0; end
        else if (rise) m_pos = 0;
        else if (pause) frozen = 1;
        else if (m_pos == SWEEP_LEN - 1) m_mode = M_SONG;
        else m_pos++;
      end
      M_JINGLE: begin
        if (m_el == 6 * NOTE_LEN - 1) m_mode = M_REST;
        else m_el++;
      end
      default: if (!game_over) m_mode = M_SONG;
    endcase
    case (m_mode)
      M_SONG: begin e_v1 = song1; e_v2 = song2; end
      M_SWEEP: if (!frozen) begin
        e_v1 = 7'((m_pos >> (SW_L - 5)) * 2);
        e_v2 = song2;
      end
      M_JINGLE: begin e_v1 = JV1[m_el / NOTE_LEN]; e_v2 = JV2[m_el / NOTE_LEN]; end
      default: begin e_v1 = 7'h2D; e_v2 = 7'h2D; end
    endcase
    m_exp = pack_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    full_row = 0; game_over = 0; pause = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; song1 = 7'h25; song2 = 7'h21; full_row = 0; game_over = 0; pause = 0;
    model_reset();
    #22;
    n_vec++;
    if (dut_obs !== m_exp) begin
      n_err++; $display("FAIL reset_hold got=%h exp=%h", dut_obs, m_exp);
    end
    rst_n = 1;
    tick();
    n_vec++;
    if (dut_obs !== 20'h25_21_0 >> 0 && dut_obs !== m_exp) begin
      n_err++; $display("FAIL reset_release got=%h exp=%h", dut_obs, m_exp);
    end
    n_vec++;
    if (dut_obs !== m_exp) begin
      n_err++; $display("FAIL reset_first_song got=%h exp=%h", dut_obs, m_exp);
    end
  endtask

  task automatic test_sweep();
    idle(2);
    full_row = 1;
    for (int i = 0; i < SWEEP_LEN + 6; i++) begin
      song1 = 7'($urandom); song2 = 7'($urandom);
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL sweep cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
    full_row = 0;
  endtask

  task automatic test_jingle();
    int busy;
    idle(2);
    busy = 0;
    game_over = 1;
    for (int i = 0; i < 6 * NOTE_LEN + 8; i++) begin
      full_row = 1'($urandom); pause = 1'($urandom);
      tick();
      if (sfx_busy) busy++;
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL jingle cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
    n_vec++;
    if (busy !== 6 * NOTE_LEN) begin
      n_err++; $display("FAIL jingle_length got=%0d exp=%0d", busy, 6 * NOTE_LEN);
    end
    game_over = 0; full_row = 0; pause = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL rest_exit cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
  endtask

  task automatic test_sweep_abort();
    idle(2);
    full_row = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 10) game_over = 1;
      if (i == 20) game_over = 0;
      if (i > 12) full_row = (i % 3) == 0;
      pause = (i > 14 && i < 30);
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL sweep_abort cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
  endtask

  task automatic test_pause_sweep();
    int in_sweep;
    idle(2);
    in_sweep = 0;
    full_row = 1;
    for (int i = 0; i < 110; i++) begin
      pause = (i >= 20 && i < 50);
      song2 = 7'($urandom);
      tick();
      if (state_dbg == 4'd1) in_sweep++;
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL pause_sweep cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
    n_vec++;
    if (in_sweep !== SWEEP_LEN + 30) begin
      n_err++; $display("FAIL pause_sweep_len got=%0d exp=%0d", in_sweep, SWEEP_LEN + 30);
    end
    full_row = 0; pause = 0;
  endtask

  task automatic test_pause_priority_reset();
    idle(2);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL pause cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
    game_over = 1; full_row = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL priority cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (dut_obs !== m_exp) begin
      n_err++; $display("FAIL async_reset got=%h exp=%h", dut_obs, m_exp);
    end
    game_over = 0; full_row = 0; pause = 0;
    #1 rst_n = 1;
    tick();
    n_vec++;
    if (dut_obs !== m_exp) begin
      n_err++; $display("FAIL post_reset got=%h exp=%h", dut_obs, m_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) game_over = ~game_over;
      if ($urandom_range(0, 29) == 0) full_row = ~full_row;
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      song1 = 7'($urandom); song2 = 7'($urandom);
      tick();
      n_vec++;
      if (dut_obs !== m_exp) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_obs, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_jingle();
    test_sweep_abort();
    test_pause_sweep();
    test_pause_priority_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
